// File: rtl/regfile_access_ctrl_if.sv
// Bus bundle between regfile_access_ctrl and its neighbours: core
// writeback, debug writer, operand fetch requester and the 16x32
// register file (registered two-port read, single write port).
// slave  = the controller, master = everything around it.
interface regfile_access_ctrl_if #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 4
);
  // core writeback writer
  logic                 wb_req_n;
  logic [ADDR_BITS-1:0] wb_addr;
  logic [DATA_BITS-1:0] wb_data;
  logic                 wb_gnt;
  // debug writer
  logic                 dbg_req_n;
  logic [ADDR_BITS-1:0] dbg_addr;
  logic [DATA_BITS-1:0] dbg_data;
  logic                 dbg_gnt;
  // operand fetch
  logic                 rd_req_n;
  logic [ADDR_BITS-1:0] rd_addr_a;
  logic [ADDR_BITS-1:0] rd_addr_b;
  logic                 rd_ready;
  logic [DATA_BITS-1:0] operand_a;
  logic [DATA_BITS-1:0] operand_b;
  logic                 operands_valid;
  // register file port
  logic                 rf_write_en_n;
  logic [ADDR_BITS-1:0] rf_write_addr;
  logic [DATA_BITS-1:0] rf_write_data;
  logic                 rf_read_en_n;
  logic [ADDR_BITS-1:0] rf_read_addr_a;
  logic [ADDR_BITS-1:0] rf_read_addr_b;
  logic [DATA_BITS-1:0] rf_read_data_a;
  logic [DATA_BITS-1:0] rf_read_data_b;

  modport slave (
    input  wb_req_n, wb_addr, wb_data,
    output wb_gnt,
    input  dbg_req_n, dbg_addr, dbg_data,
    output dbg_gnt,
    input  rd_req_n, rd_addr_a, rd_addr_b,
    output rd_ready, operand_a, operand_b, operands_valid,
    output rf_write_en_n, rf_write_addr, rf_write_data,
    output rf_read_en_n, rf_read_addr_a, rf_read_addr_b,
    input  rf_read_data_a, rf_read_data_b
  );

  modport master (
    output wb_req_n, wb_addr, wb_data,
    input  wb_gnt,
    output dbg_req_n, dbg_addr, dbg_data,
    input  dbg_gnt,
    output rd_req_n, rd_addr_a, rd_addr_b,
    input  rd_ready, operand_a, operand_b, operands_valid,
    input  rf_write_en_n, rf_write_addr, rf_write_data,
    input  rf_read_en_n, rf_read_addr_a, rf_read_addr_b,
    output rf_read_data_a, rf_read_data_b
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: sequences accesses to the 16x32 register file.
// - round-robin arbitration of the single write port (core wb vs debug)
// - IDLE/ISSUE/DONE operand fetch sequence
// - read-after-write collision handling at the read capture edge
// Optional feature macro: REGFILE_ACCESS_CTRL_BYPASS_EN
//   defined   : colliding write data is forwarded, latency is always 2
//   undefined : a collision holds the FSM in ISSUE and re-issues the read

// Per-read-port lane: latched address, collision detect, forward
// register and operand hold register.
module rac_lane #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 latch,
  input  logic [ADDR_BITS-1:0] latch_addr,
  input  logic                 issue,
  input  logic                 done,
  input  logic                 fwd_en,
  input  logic                 wr_fire,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [DATA_BITS-1:0] rd_data,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 collide,
  output logic [DATA_BITS-1:0] operand
);
  logic [DATA_BITS-1:0] fwd_data;
  logic                 fwd_vld;
  logic [DATA_BITS-1:0] held;
  logic [DATA_BITS-1:0] sel;

  // r0 is hard-wired to zero, so a write to address 0 never collides.
  assign collide = issue && wr_fire && (wr_addr != '0) && (wr_addr == addr);

  // latch the fetch address when the request is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   addr <= '0;
    else if (latch) addr <= latch_addr;
  end

  // forward register: captures colliding write data, dropped after DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fwd_vld  <= 1'b0;
      fwd_data <= '0;
    end else if (done) begin
      fwd_vld  <= 1'b0;
    end else if (fwd_en && collide) begin
      fwd_vld  <= 1'b1;
      fwd_data <= wr_data;
    end
  end

  assign sel     = fwd_vld ? fwd_data : rd_data;
  assign operand = done ? sel : held;

  // keep the last delivered operand visible outside DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  held <= '0;
    else if (done) held <= sel;
  end
endmodule

module regfile_access_ctrl #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  regfile_access_ctrl_if.slave  bus
);
  localparam int NUM_LANES = 2;  // lane 0 = operand A, lane 1 = operand B

`ifdef REGFILE_ACCESS_CTRL_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data;
  } wr_req_t;

  state_t  state, state_nxt;
  logic    last_winner;  // 1: debug won the last contest, 0: core
  logic    wb_req, dbg_req, contest, wb_win, dbg_win, wr_fire;
  wr_req_t wr;
  logic    accept, issue, done, stall;

  logic [NUM_LANES-1:0]                collide;
  logic [NUM_LANES-1:0][ADDR_BITS-1:0] lane_addr_in, lane_addr;
  logic [NUM_LANES-1:0][DATA_BITS-1:0] lane_rd_data, lane_operand;

  // ---------------- write arbitration ----------------
  // Requests are masked during reset so no grant leaks out asynchronously.
  assign wb_req  = !bus.wb_req_n  && reset_n;
  assign dbg_req = !bus.dbg_req_n && reset_n;
  assign contest = wb_req && dbg_req;
  assign wb_win  = wb_req  && (!dbg_req || last_winner);
  assign dbg_win = dbg_req && (!wb_req  || !last_winner);
  assign wr_fire = wb_win || dbg_win;

  // mux the winner onto the register file write port
  always_comb begin
    wr = '0;
    if (wb_win)       wr = '{addr: bus.wb_addr,  data: bus.wb_data};
    else if (dbg_win) wr = '{addr: bus.dbg_addr, data: bus.dbg_data};
  end

  assign bus.wb_gnt        = wb_win;
  assign bus.dbg_gnt       = dbg_win;
  assign bus.rf_write_en_n = !wr_fire;
  assign bus.rf_write_addr = wr.addr;
  assign bus.rf_write_data = wr.data;

  // round-robin bit only moves on contested cycles; reset favours core next
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     last_winner <= 1'b1;
    else if (contest) last_winner <= dbg_win;
  end

  // ---------------- read FSM ----------------
  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next state: ISSUE repeats only when a collision must be re-read
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = stall ? ISSUE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    bus.rd_ready       = 1'b0;
    bus.rf_read_en_n   = 1'b1;
    bus.operands_valid = 1'b0;
    case (state)
      IDLE:    bus.rd_ready       = 1'b1;
      ISSUE:   bus.rf_read_en_n   = 1'b0;
      DONE:    bus.operands_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept = (state == IDLE) && !bus.rd_req_n;
  assign issue  = (state == ISSUE);
  assign done   = (state == DONE);

  // With forwarding the collided port is served from the forward register,
  // otherwise the registered read must be re-captured after the write lands.
  assign stall = !BYPASS_EN && (|collide);

  // ---------------- per-port lanes ----------------
  assign lane_addr_in = {bus.rd_addr_b, bus.rd_addr_a};
  assign lane_rd_data = {bus.rf_read_data_b, bus.rf_read_data_a};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    rac_lane #(.DATA_BITS(DATA_BITS), .ADDR_BITS(ADDR_BITS)) u_lane (
      .clk        (clk),
      .reset_n    (reset_n),
      .latch      (accept),
      .latch_addr (lane_addr_in[i]),
      .issue      (issue),
      .done       (done),
      .fwd_en     (BYPASS_EN),
      .wr_fire    (wr_fire),
      .wr_addr    (wr.addr),
      .wr_data    (wr.data),
      .rd_data    (lane_rd_data[i]),
      .addr       (lane_addr[i]),
      .collide    (collide[i]),
      .operand    (lane_operand[i])
    );
  end

  assign bus.rf_read_addr_a = lane_addr[0];
  assign bus.rf_read_addr_b = lane_addr[1];
  assign bus.operand_a      = lane_operand[0];
  assign bus.operand_b      = lane_operand[1];
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural 16x32
// register file (r0 zero, registered read, old data on same-edge write).
module tb_regfile_access_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  regfile_access_ctrl_if #(.DATA_BITS(32), .ADDR_BITS(4)) bus ();

  regfile_access_ctrl #(.DATA_BITS(32), .ADDR_BITS(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // register file model
  logic [31:0] mem [16];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      bus.rf_read_data_a <= '0;
      bus.rf_read_data_b <= '0;
    end else begin
      if (!bus.rf_read_en_n) begin
        bus.rf_read_data_a <= mem[bus.rf_read_addr_a];
        bus.rf_read_data_b <= mem[bus.rf_read_addr_b];
      end
      if (!bus.rf_write_en_n && bus.rf_write_addr != 4'd0)
        mem[bus.rf_write_addr] <= bus.rf_write_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Fetch (a,b); during the first nwr cycles after acceptance the core
  // writes d0 then d1 to wa. Returns latency in cycles (0 = never valid).
  task automatic fetch(input logic [3:0] a, input logic [3:0] b, input int nwr,
                       input logic [3:0] wa, input logic [31:0] d0, input logic [31:0] d1,
                       output int lat, output logic [31:0] oa, output logic [31:0] ob);
    bus.rd_req_n  = 1'b0;
    bus.rd_addr_a = a;
    bus.rd_addr_b = b;
    #1;
    chk("fetch_ready", {31'd0, bus.rd_ready}, 32'd1);
    lat = 0; oa = '0; ob = '0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      step();
      bus.rd_req_n = 1'b1;
      if (cyc <= nwr) begin
        bus.wb_req_n = 1'b0;
        bus.wb_addr  = wa;
        bus.wb_data  = (cyc == 1) ? d0 : d1;
      end else begin
        bus.wb_req_n = 1'b1;
      end
      #1;
      if (bus.operands_valid) begin
        lat = cyc; oa = bus.operand_a; ob = bus.operand_b;
        break;
      end
    end
    step();
    bus.wb_req_n = 1'b1;
  endtask

  int          lat, cnt;
  logic [31:0] oa, ob;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wb_req_n = 1'b0; bus.wb_addr = 4'd2; bus.wb_data = 32'h1;
    bus.dbg_req_n = 1'b1; bus.dbg_addr = '0; bus.dbg_data = '0;
    bus.rd_req_n = 1'b1; bus.rd_addr_a = '0; bus.rd_addr_b = '0;

    // reset state, with a write request pending that must not be granted
    step(); step();
    chk("rst_rd_ready",  {31'd0, bus.rd_ready},       32'd1);
    chk("rst_rd_en_n",   {31'd0, bus.rf_read_en_n},   32'd1);
    chk("rst_valid",     {31'd0, bus.operands_valid}, 32'd0);
    chk("rst_op_a",      bus.operand_a,               32'd0);
    chk("rst_wb_gnt",    {31'd0, bus.wb_gnt},         32'd0);
    chk("rst_wr_en_n",   {31'd0, bus.rf_write_en_n},  32'd1);
    bus.wb_req_n = 1'b1;
    reset_n = 1'b1;
    step();

    // debug-only write r3 = 0xA5
    bus.dbg_req_n = 1'b0; bus.dbg_addr = 4'd3; bus.dbg_data = 32'hA5;
    #1;
    chk("dbg_only_gnt",  {31'd0, bus.dbg_gnt},       32'd1);
    chk("dbg_only_wb",   {31'd0, bus.wb_gnt},        32'd0);
    chk("dbg_only_addr", {28'd0, bus.rf_write_addr}, 32'd3);
    step();
    bus.dbg_req_n = 1'b1;

    // basic fetch a=3, b=0, cycle by cycle
    bus.rd_req_n = 1'b0; bus.rd_addr_a = 4'd3; bus.rd_addr_b = 4'd0;
    #1;
    chk("f1_n_ready",   {31'd0, bus.rd_ready},       32'd1);
    chk("f1_n_rd_en_n", {31'd0, bus.rf_read_en_n},   32'd1);
    step(); bus.rd_req_n = 1'b1; #1;
    chk("f1_n1_rd_en_n", {31'd0, bus.rf_read_en_n},   32'd0);
    chk("f1_n1_valid",   {31'd0, bus.operands_valid}, 32'd0);
    chk("f1_n1_ready",   {31'd0, bus.rd_ready},       32'd0);
    chk("f1_n1_addr_a",  {28'd0, bus.rf_read_addr_a}, 32'd3);
    step(); #1;
    chk("f1_n2_valid",   {31'd0, bus.operands_valid}, 32'd1);
    chk("f1_n2_op_a",    bus.operand_a,               32'hA5);
    chk("f1_n2_op_b",    bus.operand_b,               32'd0);
    chk("f1_n2_rd_en_n", {31'd0, bus.rf_read_en_n},   32'd1);
    step(); #1;
    chk("f1_n3_valid",   {31'd0, bus.operands_valid}, 32'd0);
    chk("f1_n3_hold_a",  bus.operand_a,               32'hA5);
    chk("f1_n3_ready",   {31'd0, bus.rd_ready},       32'd1);

    // contested writes: core wins first, then alternation
    for (int k = 0; k < 4; k++) begin
      bus.wb_req_n  = 1'b0; bus.wb_addr  = 4'd5; bus.wb_data  = 32'h5500_0000 | k;
      bus.dbg_req_n = 1'b0; bus.dbg_addr = 4'd6; bus.dbg_data = 32'h6600_0000 | k;
      #1;
      chk($sformatf("rr%0d_wb_gnt", k),  {31'd0, bus.wb_gnt},  (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_dbg_gnt", k), {31'd0, bus.dbg_gnt}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_wr_en_n", k), {31'd0, bus.rf_write_en_n}, 32'd0);
      chk($sformatf("rr%0d_addr", k),    {28'd0, bus.rf_write_addr}, (k % 2 == 0) ? 32'd5 : 32'd6);
      step();
    end
    bus.wb_req_n = 1'b1; bus.dbg_req_n = 1'b1;
    fetch(4'd5, 4'd6, 0, 4'd0, 32'd0, 32'd0, lat, oa, ob);
    chk("rr_lat", lat, 32'd2);
    chk("rr_r5",  oa,  32'h5500_0002);
    chk("rr_r6",  ob,  32'h6600_0003);

    // collision on r7 in ISSUE
    fetch(4'd7, 4'd0, 1, 4'd7, 32'h1234_5678, 32'd0, lat, oa, ob);
`ifdef REGFILE_ACCESS_CTRL_BYPASS_EN
    chk("col7_lat", lat, 32'd2);
`else
    chk("col7_lat", lat, 32'd3);
`endif
    chk("col7_op_a", oa, 32'h1234_5678);
    chk("col7_op_b", ob, 32'd0);

    // write to r0 in ISSUE never collides
    fetch(4'd0, 4'd0, 1, 4'd0, 32'hDEAD_BEEF, 32'd0, lat, oa, ob);
    chk("r0_lat",  lat, 32'd2);
    chk("r0_op_a", oa,  32'd0);
    chk("r0_op_b", ob,  32'd0);

    // two consecutive colliding writes to r9 on both ports
    fetch(4'd9, 4'd9, 2, 4'd9, 32'h1, 32'h2, lat, oa, ob);
`ifdef REGFILE_ACCESS_CTRL_BYPASS_EN
    chk("col9_lat",  lat, 32'd2);
    chk("col9_op_a", oa,  32'h1);
    chk("col9_op_b", ob,  32'h1);
`else
    chk("col9_lat",  lat, 32'd4);
    chk("col9_op_a", oa,  32'h2);
    chk("col9_op_b", ob,  32'h2);
`endif

    // reset during ISSUE aborts the fetch
    bus.rd_req_n = 1'b0; bus.rd_addr_a = 4'd3; bus.rd_addr_b = 4'd5;
    step(); bus.rd_req_n = 1'b1; #1;
    chk("abort_issue_rd_en_n", {31'd0, bus.rf_read_en_n}, 32'd0);
    reset_n = 1'b0; #1;
    chk("abort_rd_en_n", {31'd0, bus.rf_read_en_n},   32'd1);
    chk("abort_ready",   {31'd0, bus.rd_ready},       32'd1);
    chk("abort_valid",   {31'd0, bus.operands_valid}, 32'd0);
    chk("abort_op_a",    bus.operand_a,               32'd0);
    step(); step();
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.operands_valid) cnt++;
    end
    chk("abort_no_valid", cnt, 32'd0);
    chk("abort_ready_after", {31'd0, bus.rd_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
